// File: rtl/pcie_msg_arbiter_pkg.sv
// Message field positions, read-FSM encodings and small decode helpers shared by the
// PCIe register-message arbiter files.
package pcie_msg_arbiter_pkg;

  localparam int MSG_RESP_BIT = 63;
  localparam int MSG_WR_BIT   = 62;
  localparam int MSG_RD_BIT   = 61;
  localparam int MSG_HALF_BIT = 60;
  localparam int MSG_ADDR_LSB = 32;
  localparam int MSG_ADDR_W   = 20;

  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RD_RESP = 2'd2;

  // Synthetic response handed to the owner when the core never answers a read.
  localparam logic [63:0] MSG_TIMEOUT_RSP = {1'b1, 31'h0, 32'hFFFF_FFFF};

  typedef struct packed {
    logic                  resp;
    logic                  wr;
    logic                  rd;
    logic                  half;
    logic [7:0]            rsvd;
    logic [MSG_ADDR_W-1:0] addr;
    logic [31:0]           data;
  } msg_t;

  function automatic logic msg_is_read(input logic [63:0] m);
    return m[MSG_RD_BIT];
  endfunction

  function automatic logic msg_is_resp(input logic [63:0] m);
    return m[MSG_RESP_BIT];
  endfunction

endpackage

// File: rtl/pcie_msg_arbiter_if.sv
// Bundle of all message streams around the arbiter: requester side, core msgi/msgo,
// event port and sticky error flags. The slave modport is the arbiter's view.
interface pcie_msg_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [64*NUM_REQ-1:0] req_tdata;
  logic [NUM_REQ-1:0]    req_tvalid;
  logic [NUM_REQ-1:0]    req_tready;
  logic [63:0]           rsp_tdata;
  logic [NUM_REQ-1:0]    rsp_tvalid;
  logic [NUM_REQ-1:0]    rsp_tready;
  logic [63:0]           msgi_tdata;
  logic                  msgi_tvalid;
  logic                  msgi_tready;
  logic [63:0]           msgo_tdata;
  logic                  msgo_tvalid;
  logic                  msgo_tready;
  logic [63:0]           evt_tdata;
  logic                  evt_tvalid;
  logic                  evt_tready;
  logic                  err_timeout;
  logic                  err_stray;
  logic                  err_clr;

  modport slave (
    input  req_tdata, req_tvalid, rsp_tready, msgi_tready, msgo_tdata, msgo_tvalid,
           evt_tready, err_clr,
    output req_tready, rsp_tdata, rsp_tvalid, msgi_tdata, msgi_tvalid, msgo_tready,
           evt_tdata, evt_tvalid, err_timeout, err_stray
  );

  modport master (
    output req_tdata, req_tvalid, rsp_tready, msgi_tready, msgo_tdata, msgo_tvalid,
           evt_tready, err_clr,
    input  req_tready, rsp_tdata, rsp_tvalid, msgi_tdata, msgi_tvalid, msgo_tready,
           evt_tdata, evt_tvalid, err_timeout, err_stray
  );

endinterface

// File: rtl/pcie_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after ptr, wrapping.
// The pointer itself is owned and advanced by the parent.
module pcie_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [N-1:0] elig;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_elig
      assign elig[gi] = req[gi] & mask[gi];
    end
  endgenerate

  always_comb begin
    logic [IW-1:0] j;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    j           = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!grant_valid && elig[j]) begin
        grant_valid = 1'b1;
        grant_idx   = j;
        grant[j]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_msg_arbiter.sv
// Shares the core's 64-bit register-message port among NUM_REQ requesters, one read in flight.
// Optional read watchdog is compiled in with the PCIE_ARB_TIMEOUT_EN macro.
module pcie_msg_arbiter
  import pcie_msg_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               rst_n,
  pcie_msg_arbiter_if.slave bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [1:0]         rd_state_reg, rd_state_next;
  logic [PW-1:0]      rr_ptr_reg;
  logic [PW-1:0]      owner_reg;
  logic               out_valid_reg;
  logic [63:0]        out_data_reg;
  logic [63:0]        rsp_data_reg;
  logic               err_stray_reg;

  logic [NUM_REQ-1:0] rd_ok;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      grant_idx;
  logic               grant_any;
  logic               load;
  msg_t               win_msg;
  logic               msgo_is_rsp;
  logic               rsp_accept;
  logic               stray_hit;
  logic               rsp_done;
  logic               timeout_hit;
  logic [NUM_REQ-1:0] rsp_valid;

  // Reads are only eligible while no other read is in flight.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rd_ok
      assign rd_ok[gi] = !msg_is_read(bus.req_tdata[64*gi +: 64]) || (rd_state_reg == RD_IDLE);
    end
  endgenerate

  pcie_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req         (bus.req_tvalid),
    .mask        (rd_ok),
    .ptr         (rr_ptr_reg),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_any)
  );

  assign load           = grant_any && (!out_valid_reg || bus.msgi_tready);
  assign win_msg        = msg_t'(bus.req_tdata[{grant_idx, 6'b0} +: 64]);
  assign bus.req_tready = load ? grant : '0;
  assign bus.msgi_tvalid = out_valid_reg;
  assign bus.msgi_tdata  = out_data_reg;

  // Non-response core traffic bypasses the read FSM entirely.
  assign msgo_is_rsp     = msg_is_resp(bus.msgo_tdata);
  assign bus.evt_tdata   = bus.msgo_tdata;
  assign bus.evt_tvalid  = bus.msgo_tvalid && !msgo_is_rsp;
  assign bus.msgo_tready = msgo_is_rsp ? (rd_state_reg != RD_RESP) : bus.evt_tready;

  assign rsp_accept = bus.msgo_tvalid && msgo_is_rsp && (rd_state_reg == RD_WAIT);
  assign stray_hit  = bus.msgo_tvalid && msgo_is_rsp && (rd_state_reg == RD_IDLE);
  assign rsp_done   = (rd_state_reg == RD_RESP) && bus.rsp_tready[owner_reg];

  always_comb begin
    rsp_valid = '0;
    if (rd_state_reg == RD_RESP) rsp_valid[owner_reg] = 1'b1;
  end

  assign bus.rsp_tvalid = rsp_valid;
  assign bus.rsp_tdata  = rsp_data_reg;
  assign bus.err_stray  = err_stray_reg;

  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      RD_IDLE: if (load && win_msg.rd)           rd_state_next = RD_WAIT;
      RD_WAIT: if (rsp_accept || timeout_hit)    rd_state_next = RD_RESP;
      RD_RESP: if (rsp_done)                     rd_state_next = RD_IDLE;
      default:                                   rd_state_next = RD_IDLE;
    endcase
  end

`ifdef PCIE_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt_reg;
  logic        err_timeout_reg;

  assign timeout_hit = (rd_state_reg == RD_WAIT) && !rsp_accept &&
                       (wait_cnt_reg == 32'(TIMEOUT_CYCLES - 1));

  // Counter is held at zero outside RD_WAIT, so it starts from zero on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg    <= '0;
      err_timeout_reg <= 1'b0;
    end else begin
      wait_cnt_reg <= (rd_state_reg == RD_WAIT) ? wait_cnt_reg + 32'd1 : 32'd0;
      if (timeout_hit)      err_timeout_reg <= 1'b1;
      else if (bus.err_clr) err_timeout_reg <= 1'b0;
    end
  end

  assign bus.err_timeout = err_timeout_reg;
`else
  assign timeout_hit = 1'b0;
  // Without the watchdog the flag is constant; the term keeps the parameter referenced.
  assign bus.err_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_reg  <= RD_IDLE;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      rsp_data_reg  <= '0;
      err_stray_reg <= 1'b0;
    end else begin
      rd_state_reg <= rd_state_next;
      if (load) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= win_msg;
        rr_ptr_reg    <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
        if (win_msg.rd) owner_reg <= grant_idx;
      end else if (bus.msgi_tready) begin
        out_valid_reg <= 1'b0;
      end
      if (rsp_accept)       rsp_data_reg <= bus.msgo_tdata;
      else if (timeout_hit) rsp_data_reg <= MSG_TIMEOUT_RSP;
      if (stray_hit)        err_stray_reg <= 1'b1;
      else if (bus.err_clr) err_stray_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcie_msg_arbiter.sv
// Self-checking bench for pcie_msg_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a transaction-level model.
module tb_pcie_msg_arbiter;

  localparam int NR = 4;
`ifdef PCIE_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pcie_msg_arbiter_if #(.NUM_REQ(NR)) bus ();

  pcie_msg_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: a held outbound message, a rotating preference, and one read "ticket"
  // (phase 0 = none, 1 = awaiting core answer, 2 = answer waiting for requester).
  bit          m_held_v;
  logic [63:0] m_held_d;
  logic [1:0]  m_ptr;
  int          m_phase;
  logic [1:0]  m_owner;
  logic [63:0] m_rsp;
  bit          m_stray;
  bit          m_tmo;
  logic [3:0]  m_grant;
  logic [1:0]  m_win;
  bit          m_found;
`ifdef PCIE_ARB_TIMEOUT_EN
  int          m_wait;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held_v = 0; m_held_d = '0; m_ptr = '0; m_phase = 0; m_owner = '0;
    m_rsp = '0; m_stray = 0; m_tmo = 0; m_grant = '0; m_win = '0; m_found = 0;
`ifdef PCIE_ARB_TIMEOUT_EN
    m_wait = 0;
`endif
  endtask

  // Settle the cycle's inputs, predict every meaningful output and compare.
  task automatic model_eval();
    logic [63:0] w;
    logic [1:0]  i;
    logic [3:0]  exp_rv;
    #1;
    m_found = 0;
    m_win   = '0;
    for (int off = 0; off < NR; off++) begin
      i = m_ptr + 2'(off);
      w = bus.req_tdata[{i, 6'b0} +: 64];
      if (!m_found && bus.req_tvalid[i] && !(w[61] && m_phase != 0)) begin
        m_found = 1;
        m_win   = i;
      end
    end
    m_grant = ((!m_held_v || bus.msgi_tready) && m_found) ? (4'b0001 << m_win) : 4'b0000;
    exp_rv  = (m_phase == 2) ? (4'b0001 << m_owner) : 4'b0000;
    chk("req_tready", bus.req_tready, m_grant);
    chk("msgi_tvalid", bus.msgi_tvalid, m_held_v);
    if (m_held_v) chk("msgi_tdata", bus.msgi_tdata, m_held_d);
    chk("rsp_tvalid", bus.rsp_tvalid, exp_rv);
    if (m_phase == 2) chk("rsp_tdata", bus.rsp_tdata, m_rsp);
    chk("evt_tvalid", bus.evt_tvalid, bus.msgo_tvalid & ~bus.msgo_tdata[63]);
    if (bus.evt_tvalid) chk("evt_tdata", bus.evt_tdata, bus.msgo_tdata);
    if (bus.msgo_tvalid)
      chk("msgo_tready", bus.msgo_tready,
          bus.msgo_tdata[63] ? (m_phase != 2) : bus.evt_tready);
    chk("err_stray", bus.err_stray, m_stray);
    chk("err_timeout", bus.err_timeout, m_tmo);
  endtask

  task automatic model_update();
    int   nph;
    bit   stray_set;
    bit   tmo_set;
    logic [63:0] w;
    nph = m_phase; stray_set = 0; tmo_set = 0;
    if (m_phase == 2 && bus.rsp_tready[m_owner]) nph = 0;
    if (bus.msgo_tvalid && bus.msgo_tdata[63]) begin
      if (m_phase == 0) stray_set = 1;
      else if (m_phase == 1) begin m_rsp = bus.msgo_tdata; nph = 2; end
    end
`ifdef PCIE_ARB_TIMEOUT_EN
    if (m_phase == 1 && nph == 1) begin
      if (m_wait == TO - 1) begin
        m_rsp = {1'b1, 31'h0, 32'hFFFF_FFFF}; tmo_set = 1; nph = 2;
      end else m_wait++;
    end
`endif
    if (m_grant != 0) begin
      w = bus.req_tdata[{m_win, 6'b0} +: 64];
      m_held_v = 1; m_held_d = w; m_ptr = m_win + 2'd1;
      if (w[61]) begin
        m_owner = m_win; nph = 1;
`ifdef PCIE_ARB_TIMEOUT_EN
        m_wait = 0;
`endif
      end
    end else if (bus.msgi_tready) m_held_v = 0;
    m_phase = nph;
    if (stray_set) m_stray = 1; else if (bus.err_clr) m_stray = 0;
    if (tmo_set) m_tmo = 1; else if (bus.err_clr) m_tmo = 0;
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req_tdata = '0; bus.req_tvalid = '0; bus.rsp_tready = '0; bus.msgi_tready = 1'b0;
    bus.msgo_tdata = '0; bus.msgo_tvalid = 1'b0; bus.evt_tready = 1'b0; bus.err_clr = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [63:0] rand_req();
    logic [1:0] kind;
    kind = 2'($urandom_range(0, 3));
    return {1'b0, kind == 2'd2, kind[0], 1'($urandom), 8'h0, 20'($urandom), 32'($urandom)};
  endfunction

  localparam logic [63:0] W_T1  = 64'h4007_b000_1234_5678;
  localparam logic [63:0] R_T3A = 64'h2006_a000_0000_0000;
  localparam logic [63:0] R_T3B = 64'h2006_b000_0000_0000;
  localparam logic [63:0] W_T3C = 64'h4006_c000_0000_00c3;
  localparam logic [63:0] EVT_W = 64'h4000_0200_00be_ef00;

  initial begin
    apply_reset();

    // Reset state
    model_eval();
    chk("rst msgi_tvalid", bus.msgi_tvalid, 1'b0);
    chk("rst rsp_tvalid", bus.rsp_tvalid, 4'b0000);
    chk("rst req_tready", bus.req_tready, 4'b0000);
    chk("rst evt_tvalid", bus.evt_tvalid, 1'b0);
    chk("rst err_stray", bus.err_stray, 1'b0);
    chk("rst err_timeout", bus.err_timeout, 1'b0);
    advance();

    // Single write, latency one
    bus.msgi_tready = 1'b1;
    bus.req_tdata[63:0] = W_T1; bus.req_tvalid = 4'b0001;
    model_eval();
    chk("t1 req_tready", bus.req_tready, 4'b0001);
    advance();
    bus.req_tvalid = '0;
    model_eval();
    chk("t1 msgi_tvalid", bus.msgi_tvalid, 1'b1);
    chk("t1 msgi_tdata", bus.msgi_tdata, W_T1);
    advance();

    // Four writers, back-to-back rotation
    apply_reset();
    bus.msgi_tready = 1'b1;
    for (int r = 0; r < NR; r++) bus.req_tdata[64*r +: 64] = {32'h4001_0000, 32'(r)};
    bus.req_tvalid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      model_eval();
      chk("t2 rotation", bus.req_tready, 4'b0001 << (k % 4));
      advance();
    end
    bus.req_tvalid = '0;
    model_eval(); advance();

    // Read lock: write passes, second read waits for the response
    bus.req_tdata[64*1 +: 64] = R_T3A; bus.req_tvalid = 4'b0010;
    model_eval(); chk("t3 rd1 grant", bus.req_tready, 4'b0010); advance();
    bus.req_tdata[64*2 +: 64] = R_T3B; bus.req_tdata[64*3 +: 64] = W_T3C;
    bus.req_tvalid = 4'b1100;
    model_eval(); chk("t3 wr3 passes", bus.req_tready, 4'b1000); advance();
    bus.req_tvalid = 4'b0100;
    model_eval(); chk("t3 rd2 blocked", bus.req_tready, 4'b0000); advance();
    bus.msgo_tdata = 64'h8000_0000_0000_0001; bus.msgo_tvalid = 1'b1;
    model_eval(); chk("t3 rsp accepted", bus.msgo_tready, 1'b1); advance();
    bus.msgo_tvalid = 1'b0; bus.rsp_tready = 4'b0010;
    model_eval();
    chk("t3 rsp owner", bus.rsp_tvalid, 4'b0010);
    chk("t3 rsp data", bus.rsp_tdata, 64'h8000_0000_0000_0001);
    chk("t3 rd2 still blocked", bus.req_tready, 4'b0000);
    advance();
    bus.rsp_tready = '0;
    model_eval(); chk("t3 rd2 grant", bus.req_tready, 4'b0100); advance();
    bus.req_tvalid = '0;
    bus.msgo_tdata = 64'h8000_0000_0000_0002; bus.msgo_tvalid = 1'b1;
    model_eval(); advance();
    bus.msgo_tvalid = 1'b0; bus.rsp_tready = 4'b1111;
    model_eval(); advance();
    bus.rsp_tready = '0;

    // Event stream back-pressure
    bus.msgo_tdata = EVT_W; bus.msgo_tvalid = 1'b1; bus.evt_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      model_eval();
      chk("t4 msgo stalled", bus.msgo_tready, 1'b0);
      advance();
    end
    bus.evt_tready = 1'b1;
    model_eval();
    chk("t4 msgo_tready", bus.msgo_tready, 1'b1);
    chk("t4 evt_tdata", bus.evt_tdata, EVT_W);
    advance();
    bus.msgo_tvalid = 1'b0;

    // Stray response and clear
    bus.msgo_tdata = 64'h8000_0000_0000_0055; bus.msgo_tvalid = 1'b1;
    model_eval(); chk("t5 stray consumed", bus.msgo_tready, 1'b1); advance();
    bus.msgo_tvalid = 1'b0; bus.err_clr = 1'b1;
    model_eval();
    chk("t5 err_stray set", bus.err_stray, 1'b1);
    chk("t5 no rsp_tvalid", bus.rsp_tvalid, 4'b0000);
    advance();
    bus.err_clr = 1'b0;
    model_eval(); chk("t5 err_stray cleared", bus.err_stray, 1'b0); advance();

`ifdef PCIE_ARB_TIMEOUT_EN
    // Watchdog: synthetic all-ones response, then late answer counts as stray
    apply_reset();
    bus.msgi_tready = 1'b1;
    bus.req_tdata[63:0] = R_T3A; bus.req_tvalid = 4'b0001;
    model_eval(); chk("t6 rd grant", bus.req_tready, 4'b0001); advance();
    bus.req_tvalid = '0;
    for (int k = 0; k < TO; k++) begin
      model_eval(); chk("t6 waiting", bus.rsp_tvalid, 4'b0000); advance();
    end
    bus.rsp_tready = 4'b0001;
    model_eval();
    chk("t6 rsp owner", bus.rsp_tvalid, 4'b0001);
    chk("t6 rsp data", bus.rsp_tdata, 64'h8000_0000_FFFF_FFFF);
    chk("t6 err_timeout", bus.err_timeout, 1'b1);
    advance();
    bus.rsp_tready = '0;
    bus.msgo_tdata = 64'h8000_0000_0000_0077; bus.msgo_tvalid = 1'b1;
    model_eval(); advance();
    bus.msgo_tvalid = 1'b0;
    model_eval(); chk("t6 late stray", bus.err_stray, 1'b1); advance();
`endif

    // Randomized traffic against the model
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      int m;
      for (int r = 0; r < NR; r++) bus.req_tdata[64*r +: 64] = rand_req();
      bus.req_tvalid  = 4'($urandom);
      bus.rsp_tready  = 4'($urandom);
      bus.msgi_tready = ($urandom_range(0, 9) < 7);
      bus.evt_tready  = 1'($urandom);
      bus.err_clr     = ($urandom_range(0, 19) == 0);
      m = $urandom_range(0, 9);
      bus.msgo_tvalid = (m < 4);
      bus.msgo_tdata  = {(m < 2), 31'($urandom), 32'($urandom)};
      model_eval();
      advance();
    end

    // Reset mid-read: nothing replayed, next read granted immediately
    apply_reset();
    bus.req_tdata[63:0] = R_T3A; bus.req_tvalid = 4'b0001; bus.msgi_tready = 1'b0;
    model_eval(); advance();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("mid-rst msgi_tvalid", bus.msgi_tvalid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    bus.msgi_tready = 1'b1;
    bus.req_tdata[64*1 +: 64] = R_T3B; bus.req_tvalid = 4'b0010;
    model_eval();
    chk("post-rst rd grant", bus.req_tready, 4'b0010);
    chk("post-rst no replay", bus.msgi_tvalid, 1'b0);
    advance();
    bus.req_tvalid = '0;
    model_eval(); advance();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
